scope_capture: RTL
==================

// Module: scope_capture
// PURPOSE
// - Multi-channel logic-capture core for the Mojo oscilloscope; replaces the single-pin capture path.
// - Sits between the AVR serial byte interface and NUM_CH external input pins.
// - Samples the pins at a programmable rate and waits for a configurable edge trigger.
// - Stores DEPTH samples in block RAM, then streams them to the host over tx_data.
// PARAMETERS
// - NUM_CH   4    number of input channels, 1..8; one sample = one byte, unused bits 0
// - DEPTH    512  samples per capture; power of two, 16..2048; ADDR_W = $clog2(DEPTH)
// - HDR_BYTE 8'hA5  frame header byte sent before sample data
// PORTS
// - clk          in   1       50 MHz system clock, all logic on posedge
// - rst_n        in   1       asynchronous active-low reset
// - ch_in        in   NUM_CH  asynchronous probe inputs
// - rx_data      in   8       received command byte
// - new_rx_data  in   1       1-cycle strobe, rx_data valid
// - tx_data      out  8       byte to transmit
// - new_tx_data  out  1       1-cycle strobe, tx_data valid
// - tx_busy      in   1       transmitter busy; no strobe while high
// - status       out  3       {sending, capturing, armed}, one-hot or 0 when idle
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, tx_data=0, new_tx_data=0, status=0, div=0, trig_cfg=0, addr=0.
// - ch_in passes a 2-flop synchroniser; the sample tick fires every (div+1) clk cycles (div=0: every clk).
// - Commands are accepted only on new_rx_data:
//   'A'(0x41) arm, honoured in IDLE only; 'X'(0x58) abort from any state to IDLE, no further tx;
//   'T'(0x54)+1 byte sets trig_cfg; 'R'(0x52)+1 byte sets div. Both honoured in IDLE only.
//   The parameter byte is the next byte received, regardless of its value. Unknown bytes are ignored.
// - trig_cfg fields: [2:0] channel index; [4] edge, 0 = rising, 1 = falling; [5] immediate trigger.
//   A channel index >= NUM_CH acts as immediate. Other bits are ignored.
// - States:
//   IDLE -'A'-> ARMED.
//   ARMED: on each tick, compare the synced sample with the previous tick's sample.
//     Selected edge (or immediate) -> CAPTURE. The triggering sample is written to addr 0.
//     The prev-sample register is loaded on the first tick after arming; no trigger on that tick.
//   CAPTURE: write one sample per tick at addr, addr++. After addr DEPTH-1 is written -> SEND, addr=0.
//   SEND: emit HDR_BYTE, then RAM[0..DEPTH-1] in order (+ checksum, see CONFIGURATION) -> IDLE.
// - TX handshake: new_tx_data pulses high for exactly 1 cycle, only when tx_busy=0.
//   After a pulse, tx_busy is ignored for 1 cycle to cover its 1-cycle lag.
//   tx_data is stable from the strobe cycle until the next strobe.
// - RAM: 1 write port and 1 read port, 1-cycle read latency. The read address is prefetched so no bubble beyond the handshake.
// - Address counter wraps at ADDR_W bits. The end of capture is detected at addr==DEPTH-1, not at wrap.
// - Abort during SEND: the current strobe, if in flight, completes. No further strobes. RAM contents are undefined afterwards.
// - 'X' and 'A' in the same byte stream: bytes are handled strictly in arrival order.
// - Reset mid-capture or mid-send: immediate return to IDLE; no partial frame continuation.
// - status: armed=1 in ARMED, capturing=1 in CAPTURE, sending=1 in SEND; all 0 in IDLE.
// CONFIGURATION
// - SCOPE_CHKSUM_EN defined: after the last sample, one extra byte is sent.
//   It is the XOR of all DEPTH sample bytes; the header is not included.
//   Frame length = DEPTH+2 bytes.
// - SCOPE_CHKSUM_EN undefined: no checksum logic. Frame length = DEPTH+1 bytes.
// TESTING
// - Reset: hold rst_n=0 with tx_busy=0 -> new_tx_data=0, status=0, no strobes for 100 cycles after release.
// - Immediate trigger: send 'T',0x20 then 'R',0x00 then 'A'; drive a ch_in counter pattern.
//   Expect 0xA5 followed by DEPTH bytes, each equal to the synced ch_in at consecutive clk cycles.
// - Rising edge, channel 2: div=3 and 'T',0x02; toggle ch_in[2] 0->1 at a known cycle.
//   Expect byte 1 (after the header) to have bit 2 = 1 and the previous sample to have had bit 2 = 0.
//   Consecutive samples must be 4 clk apart.
// - Backpressure: hold tx_busy=1 for random 1..50 cycles after each strobe.
//   Expect no strobe while busy, no lost or duplicated byte, and frame length DEPTH+1 (DEPTH+2 with SCOPE_CHKSUM_EN).
// - Abort: send 'X' in ARMED -> status=0 and no tx. Send 'X' after 10 data bytes in SEND -> no further strobes after the in-flight one.
// - Ignored commands: 'T',0x10 received in CAPTURE -> trig_cfg unchanged, capture completes normally.
//   With SCOPE_CHKSUM_EN, the last byte equals the XOR of the data bytes.

Source files
------------

// File: rtl/scope_capture_if.sv
`default_nettype none
// ============================================================================
// scope_capture_if : byte-stream bus between host serial link and scope core
// Revision: 1.0
// ============================================================================
interface scope_capture_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;

  modport master (output rx_data, new_rx_data, tx_busy, input tx_data, new_tx_data);
  modport slave  (input rx_data, new_rx_data, tx_busy, output tx_data, new_tx_data);
endinterface
`default_nettype wire

// File: rtl/scope_capture.sv
`default_nettype none
// ============================================================================
// scope_capture : multi-channel edge-triggered logic capture, streamed to host.
// Optional checksum trailer byte enabled by defining SCOPE_CHKSUM_EN.
// Revision: 1.0
// ============================================================================
module scope_capture #(
  parameter int         NUM_CH   = 4,
  parameter int         DEPTH    = 512,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [NUM_CH-1:0] ch_in,
  scope_capture_if.slave         bus,
  output logic [2:0]             status
);
  localparam int                ADDR_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST      = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        C_CMD_ARM   = 8'h41;
  localparam logic [7:0]        C_CMD_ABORT = 8'h58;
  localparam logic [7:0]        C_CMD_TRIG  = 8'h54;
  localparam logic [7:0]        C_CMD_RATE  = 8'h52;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_SEND = 2'd3} state_t;
  typedef enum logic [1:0] {P_NONE = 2'd0, P_TRIG = 2'd1, P_RATE = 2'd2} pend_t;
  typedef enum logic [1:0] {T_HDR = 2'd0, T_DATA = 2'd1, T_SUM = 2'd2} txph_t;

  state_t            r_state, w_state_next;
  pend_t             r_pend;
  txph_t             r_txph;
  logic [NUM_CH-1:0] r_sync1, r_sync2;
  logic [7:0]        w_sample, r_prev, r_div, r_div_cnt, r_rd_data, r_tx_data, w_tx_byte;
  logic [2:0]        r_trig_ch;
  logic              r_trig_fall, r_trig_imm, r_first, r_hold, r_tx_stb;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        mem [DEPTH];
  logic              w_cmd, w_arm, w_abort, w_tick, w_imm, w_edge, w_trig, w_tx_ok;
  logic              w_we, w_tx_fire;
`ifdef SCOPE_CHKSUM_EN
  logic [7:0]        r_chk;
`endif

  assign w_sample = 8'(r_sync2);
  // A byte following 'T'/'R' is always a parameter, never a command.
  assign w_cmd    = bus.new_rx_data && (r_pend == P_NONE);
  assign w_arm    = w_cmd && (bus.rx_data == C_CMD_ARM) && (r_state == S_IDLE);
  assign w_abort  = w_cmd && (bus.rx_data == C_CMD_ABORT);
  assign w_tick   = (r_div_cnt == r_div);
  assign w_imm    = r_trig_imm || (int'(r_trig_ch) >= NUM_CH);
  assign w_edge   = r_trig_fall ? (r_prev[r_trig_ch] && !w_sample[r_trig_ch])
                                : (!r_prev[r_trig_ch] && w_sample[r_trig_ch]);
  assign w_trig   = w_tick && !r_first && (w_imm || w_edge);
  assign w_tx_ok  = !bus.tx_busy && !r_hold;

  assign bus.tx_data     = r_tx_data;
  assign bus.new_tx_data = r_tx_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_state <= w_state_next;
      r_sync1 <= ch_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_tx_fire    = 1'b0;
    w_tx_byte    = r_rd_data;
    case (r_state)
      S_IDLE:    if (w_arm) w_state_next = S_ARMED;
      S_ARMED:   if (w_trig) begin
                   w_we         = 1'b1;
                   w_state_next = S_CAPTURE;
                 end
      S_CAPTURE: if (w_tick) begin
                   w_we = 1'b1;
                   if (r_addr == C_LAST) w_state_next = S_SEND;
                 end
      S_SEND:    if (w_tx_ok) begin
                   w_tx_fire = 1'b1;
                   case (r_txph)
                     T_HDR:   w_tx_byte = HDR_BYTE;
                     T_DATA:  begin
`ifndef SCOPE_CHKSUM_EN
                                if (r_addr == C_LAST) w_state_next = S_IDLE;
`endif
                              end
                     default: begin
`ifdef SCOPE_CHKSUM_EN
                                w_tx_byte = r_chk;
`endif
                                w_state_next = S_IDLE;
                              end
                   endcase
                 end
      default:   w_state_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_next = S_IDLE;
      w_we         = 1'b0;
      w_tx_fire    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= P_NONE;
      r_trig_ch   <= '0;
      r_trig_fall <= 1'b0;
      r_trig_imm  <= 1'b0;
      r_div       <= '0;
      r_div_cnt   <= '0;
    end else begin
      r_div_cnt <= w_tick ? 8'd0 : r_div_cnt + 8'd1;
      if (bus.new_rx_data) begin
        r_pend <= P_NONE;
        if (r_pend == P_TRIG) begin
          r_trig_ch   <= bus.rx_data[2:0];
          r_trig_fall <= bus.rx_data[4];
          r_trig_imm  <= bus.rx_data[5];
        end else if (r_pend == P_RATE) begin
          r_div     <= bus.rx_data;
          r_div_cnt <= 8'd0;
        end else if (r_state == S_IDLE && bus.rx_data == C_CMD_TRIG) begin
          r_pend <= P_TRIG;
        end else if (r_state == S_IDLE && bus.rx_data == C_CMD_RATE) begin
          r_pend <= P_RATE;
        end
      end
    end
  end

  // r_addr is the write pointer while capturing and the read pointer while sending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_prev    <= '0;
      r_first   <= 1'b0;
      r_txph    <= T_HDR;
      r_hold    <= 1'b0;
      r_tx_stb  <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_stb <= w_tx_fire;
      r_hold   <= w_tx_fire;
      if (w_arm) begin
        r_addr  <= '0;
        r_first <= 1'b1;
        r_txph  <= T_HDR;
      end
      if (r_state == S_ARMED && w_tick) begin
        r_prev  <= w_sample;
        r_first <= 1'b0;
      end
      if (w_we) r_addr <= r_addr + 1'b1;
      if (w_tx_fire) begin
        r_tx_data <= w_tx_byte;
        case (r_txph)
          T_HDR:   r_txph <= T_DATA;
          T_DATA:  begin
                     r_addr <= r_addr + 1'b1;
                     if (r_addr == C_LAST) r_txph <= T_SUM;
                   end
          default: r_txph <= T_HDR;
        endcase
      end
      if (w_abort) r_addr <= '0;
    end
  end

`ifdef SCOPE_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_chk <= '0;
    else if (w_arm)                            r_chk <= '0;
    else if (w_tx_fire && r_txph == T_DATA)    r_chk <= r_chk ^ r_rd_data;
  end
`endif

  // Sample store: read port follows r_addr continuously, so data is ready
  // during the one-cycle handshake hold after each strobe.
  always_ff @(posedge clk) begin
    if (w_we) mem[r_addr] <= w_sample;
    r_rd_data <= mem[r_addr];
  end

  always_comb begin
    status = 3'b000;
    case (r_state)
      S_ARMED:   status = 3'b001;
      S_CAPTURE: status = 3'b010;
      S_SEND:    status = 3'b100;
      default:   status = 3'b000;
    endcase
  end
endmodule
`default_nettype wire
